// File: rtl/counter_param.sv
// counter_param
//   Parametrised timing/event counter with programmable width and modulus,
//   up/down direction, wrap or saturate behaviour at the limits, a prescaled
//   step tick, a synchronous load, a one-cycle terminal-count pulse and a
//   sticky overflow flag.
//
// Parameters
//   WIDTH     counter width in bits (1..32)
//   MAX_VAL   terminal value when counting up (<= 2**WIDTH-1)
//   PRESCALE  enabled cycles per count step (1..256)
//   RESET_VAL count value after reset (<= MAX_VAL)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   en        advance prescaler / counter
//   up_dn     1 = count up, 0 = count down (sampled on tick edges only)
//   sat_mode  1 = saturate at the limit, 0 = wrap (sampled on tick edges only)
//   load      synchronous load of load_val, clipped to MAX_VAL
//   load_val  load value
//   clr_ovf   clear sticky overflow flag (a same-edge terminal event wins)
//   count     current count, registered
//   tc        one-cycle terminal-count pulse, registered
//   ovf       sticky overflow flag, registered
module counter_param #(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_VAL   = 255,
    parameter int          PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Prescaler only needs to hold 0..PRESCALE-1; keep at least one bit.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_param: WIDTH must be in 1..32");
    end
    if ((64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_max
        $error("counter_param: MAX_VAL does not fit in WIDTH bits");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("counter_param: PRESCALE must be in 1..256");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("counter_param: RESET_VAL must not exceed MAX_VAL");
    end

    logic [PW-1:0]    presc;
    logic             tick;
    logic             at_limit;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clip;

    always_comb begin
        tick      = en && (presc == PS_LAST);
        at_limit  = up_dn ? (count == MAX_C) : (count == '0);
        load_clip = (load_val > MAX_C) ? MAX_C : load_val;
        step_val  = count;
        if (up_dn) begin
            if (!at_limit)     step_val = count + WIDTH'(1);
            else if (!sat_mode) step_val = '0;
        end else begin
            if (!at_limit)     step_val = count - WIDTH'(1);
            else if (!sat_mode) step_val = MAX_C;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_C;
            presc <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            // tc is a pulse: low unless this edge is a terminal event.
            tc <= 1'b0;
            // clr_ovf acts on every edge; a terminal event below overrides it.
            if (clr_ovf) ovf <= 1'b0;

            if (load) begin
                count <= load_clip;
                presc <= '0;
            end else if (en) begin
                if (tick) begin
                    presc <= '0;
                    count <= step_val;
                    if (at_limit) begin
                        tc  <= 1'b1;
                        ovf <= 1'b1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_param.sv
module tb_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       sat_mode;
    logic       load;
    logic [7:0] load_val;
    logic       clr_ovf;

    logic [7:0] count_a, count_b;
    logic       tc_a, tc_b, ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // u_a: small modulus, step every enabled cycle.
    counter_param #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .count(count_a), .tc(tc_a), .ovf(ovf_a)
    );

    // u_b: modulus 100, step every fourth enabled cycle.
    counter_param #(.WIDTH(8), .MAX_VAL(99), .PRESCALE(4), .RESET_VAL(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .count(count_b), .tc(tc_b), .ovf(ovf_b)
    );

    // ---------------- driver tasks ----------------
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic u, input logic s,
                         input logic l, input logic [7:0] lv, input logic c);
        en       = e;
        up_dn    = u;
        sat_mode = s;
        load     = l;
        load_val = lv;
        clr_ovf  = c;
    endtask

    // Load a value in one edge, leaving all controls idle afterwards.
    task automatic load_value(input logic [7:0] v);
        drive(1'b0, 1'b1, 1'b0, 1'b1, v, 1'b0);
        tick_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    // Assert reset between edges, leave it released before the next edge.
    task automatic pulse_reset_mid();
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e;

        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        rst = 1'b0;
        #2;
        check("reset_count_a", count_a, 0);
        check("reset_tc_a", tc_a, 0);
        check("reset_ovf_a", ovf_a, 0);
        check("reset_count_b", count_b, 0);
        release_reset();

        // Hold after release with en=0.
        tick_clk();
        tick_clk();
        check("hold_after_release", count_a, 0);

        // Wrap up, MAX_VAL=9: 1..9,0 with tc only on the wrap.
        for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            e = exp_q.pop_front();
            check("wrap_up_count", count_a, e);
            check("wrap_up_tc", tc_a, (e == 8'd0) ? 1 : 0);
            if (i == 8) check("wrap_up_ovf_before", ovf_a, 0);
        end
        check("wrap_up_ovf", ovf_a, 1);

        // Load leaves ovf alone; clr_ovf on a wrap edge loses to the set.
        load_value(8'd9);
        check("load9_count", count_a, 9);
        check("load_ovf_kept", ovf_a, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        tick_clk();
        check("clr_on_wrap_count", count_a, 0);
        check("clr_on_wrap_tc", tc_a, 1);
        check("clr_on_wrap_ovf", ovf_a, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        tick_clk();
        check("clr_no_event_ovf", ovf_a, 0);
        check("clr_no_event_tc", tc_a, 0);
        check("clr_no_event_count", count_a, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

        // Wrap down from 0 goes to MAX_VAL.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick_clk();
        check("wrap_down_count", count_a, 9);
        check("wrap_down_tc", tc_a, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

        // Saturate up: 8 -> 9 -> 9(tc).
        load_value(8'd8);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        tick_clk();
        check("sat_up_count1", count_a, 9);
        check("sat_up_tc1", tc_a, 0);
        tick_clk();
        check("sat_up_count2", count_a, 9);
        check("sat_up_tc2", tc_a, 1);

        // Saturate down from 2: 1,0,0,0 with tc on cycles 3 and 4.
        rst = 1'b0;
        #1;
        release_reset();
        load_value(8'd2);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick_clk();
            e = exp_q.pop_front();
            check("sat_down_count", count_a, e);
            check("sat_down_tc", tc_a, (i >= 3) ? 1 : 0);
        end
        check("sat_down_ovf", ovf_a, 1);

        // tc is high now; async reset drops everything before any edge.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        pulse_reset_mid();
        check("async_rst_tc", tc_a, 0);
        check("async_rst_ovf", ovf_a, 0);
        release_reset();

        // Reset mid-count on u_b at 37.
        load_value(8'd37);
        check("load37_count", count_b, 37);
        pulse_reset_mid();
        check("mid_rst_count", count_b, 0);
        check("mid_rst_tc", tc_b, 0);
        check("mid_rst_ovf", ovf_b, 0);
        release_reset();
        tick_clk();
        tick_clk();
        check("mid_rst_hold", count_b, 0);

        // Prescale 4: count = k/4 over 12 enabled cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 1; k <= 12; k++) exp_q.push_back(8'(k / 4));
        for (int k = 1; k <= 12; k++) begin
            tick_clk();
            e = exp_q.pop_front();
            check("presc_count", count_b, e);
        end
        // Two enabled, two idle, then the step lands after two more enabled.
        tick_clk();
        tick_clk();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick_clk();
        tick_clk();
        check("presc_idle_hold", count_b, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick_clk();
        check("presc_resume_1", count_b, 3);
        tick_clk();
        check("presc_resume_2", count_b, 4);

        // Load clip with en=1 mid-prescale: count=99, tc=0, prescaler restarted.
        tick_clk();
        tick_clk();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 1'b0);
        tick_clk();
        check("load_clip_count", count_b, 99);
        check("load_clip_tc", tc_b, 0);
        check("load_clip_ovf", ovf_b, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick_clk();
            check("post_load_no_step", count_b, 99);
        end
        tick_clk();
        check("post_load_wrap_count", count_b, 0);
        check("post_load_wrap_tc", tc_b, 1);
        check("post_load_wrap_ovf", ovf_b, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 1'b0);
        tick_clk();
        check("reload_clip_count", count_b, 99);
        check("reload_ovf_kept", ovf_b, 1);
        check("reload_tc", tc_b, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd50, 1'b0);
        tick_clk();
        check("load_in_range", count_b, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
